// File: rtl/seg_led_dynamic_count.sv
// Six-digit BCD event counter with time-multiplexed, active-low 7-segment drive
// and optional leading-zero blanking.
module seg_led_dynamic_count #(
    parameter logic [15:0] SCAN_DIV = 16'd50_000,
    parameter logic        BLANK_LZ = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        add_flag,
    input  logic        en,
    input  logic        clr,
    output logic [5:0]  sel,
    output logic [7:0]  sel_led,
    output logic [23:0] count_bcd,
    output logic        wrap
);

    logic [23:0] count_reg;
    logic [23:0] count_next;
    logic        wrap_reg;
    logic        wrap_next;
    logic [15:0] div_reg;
    logic [15:0] div_next;
    logic [2:0]  idx_reg;
    logic [2:0]  idx_next;
    logic [5:0]  sel_reg;
    logic [5:0]  sel_next;
    logic [7:0]  sel_led_reg;
    logic [7:0]  sel_led_next;
    logic [5:0]  lower_nines;
    logic [5:0]  upper_zero;
    logic [3:0]  cur_digit;
    logic        cur_blank;
    logic        inc;

    assign inc = add_flag & en;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    // A digit steps when every digit below it is 9; flat compares avoid a ripple net.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign lower_nines[gi] = 1'b1;
            end else begin : g_upper
                assign lower_nines[gi] = (count_reg[4*gi-1:0] == {gi{4'h9}});
            end
            assign upper_zero[gi] = (count_reg[23:4*gi] == '0);
            assign count_next[4*gi +: 4] =
                !(inc && lower_nines[gi])       ? count_reg[4*gi +: 4] :
                (count_reg[4*gi +: 4] == 4'd9)  ? 4'd0 :
                                                  count_reg[4*gi +: 4] + 4'd1;
        end
    endgenerate

    assign wrap_next = inc & ~clr & (count_reg == 24'h999999);

    always_comb begin
        div_next = (div_reg == SCAN_DIV - 16'd1) ? 16'd0 : div_reg + 16'd1;
        idx_next = idx_reg;
        if (div_reg == SCAN_DIV - 16'd1) begin
            idx_next = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (idx_reg == 3'(i)) begin
                cur_digit = count_reg[4*i +: 4];
                cur_blank = (i != 0) && upper_zero[i];
            end
        end
        sel_next     = ~(6'b000001 << idx_reg);
        sel_led_next = (BLANK_LZ && cur_blank) ? 8'hFF : seg7(cur_digit);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count_reg   <= '0;
            wrap_reg    <= 1'b0;
            div_reg     <= '0;
            idx_reg     <= '0;
            sel_reg     <= 6'b111110;
            sel_led_reg <= 8'hC0;
        end else begin
            count_reg   <= clr ? 24'h000000 : count_next;
            wrap_reg    <= wrap_next;
            div_reg     <= div_next;
            idx_reg     <= idx_next;
            sel_reg     <= sel_next;
            sel_led_reg <= sel_led_next;
        end
    end

    assign sel       = sel_reg;
    assign sel_led   = sel_led_reg;
    assign count_bcd = count_reg;
    assign wrap      = wrap_reg;

endmodule

// File: tb/tb_seg_led_dynamic_count.sv
// Randomized bench for seg_led_dynamic_count: integer-valued reference model checked
// every cycle on two instances (blanking on / off), plus literal spot checks.
module tb_seg_led_dynamic_count;

    localparam int SD_A = 4;
    localparam int SD_B = 3;
    localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic add_flag = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;

    logic [5:0]  sel_a, sel_b;
    logic [7:0]  led_a, led_b;
    logic [23:0] cnt_a, cnt_b;
    logic        wrap_a, wrap_b;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 sys_clk = ~sys_clk;

    seg_led_dynamic_count #(.SCAN_DIV(16'(SD_A)), .BLANK_LZ(1'b1)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .add_flag(add_flag), .en(en), .clr(clr),
        .sel(sel_a), .sel_led(led_a), .count_bcd(cnt_a), .wrap(wrap_a)
    );

    seg_led_dynamic_count #(.SCAN_DIV(16'(SD_B)), .BLANK_LZ(1'b0)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .add_flag(add_flag), .en(en), .clr(clr),
        .sel(sel_b), .sel_led(led_b), .count_bcd(cnt_b), .wrap(wrap_b)
    );

    // Reference: the count is a plain integer, the scan position is cycles-since-reset.
    int         m_cnt = 0;
    int         m_t = 0;
    logic       m_wrap = 1'b0;
    logic [5:0] m_sel_a = 6'b111110, m_sel_b = 6'b111110;
    logic [7:0] m_led_a = 8'hC0, m_led_b = 8'hC0;

    function automatic logic [7:0] seg_code(input int cnt, input int idx, input bit blank_en);
        int p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        if (blank_en && idx > 0 && cnt < p) return 8'hFF;
        return SEG_TAB[(cnt / p) % 10];
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r = '0;
        int x = v;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge sys_clk) begin
        int ia, ib;
        if (sys_rst) begin
            m_cnt = 0; m_t = 0; m_wrap = 1'b0;
            m_sel_a = 6'b111110; m_sel_b = 6'b111110;
            m_led_a = 8'hC0;     m_led_b = 8'hC0;
        end else begin
            ia = (m_t / SD_A) % 6;
            ib = (m_t / SD_B) % 6;
            m_sel_a = ~(6'b000001 << ia);
            m_sel_b = ~(6'b000001 << ib);
            m_led_a = seg_code(m_cnt, ia, 1'b1);
            m_led_b = seg_code(m_cnt, ib, 1'b0);
            m_wrap = 1'b0;
            if (clr) begin
                m_cnt = 0;
            end else if (add_flag && en) begin
                if (m_cnt == 999999) begin
                    m_cnt = 0;
                    m_wrap = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_t = m_t + 1;
        end
    end

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (chk_on) begin
            check("count_a", cnt_a, to_bcd(m_cnt));
            check("count_b", cnt_b, to_bcd(m_cnt));
            check("wrap_a", 24'(wrap_a), 24'(m_wrap));
            check("wrap_b", 24'(wrap_b), 24'(m_wrap));
            check("sel_a", 24'(sel_a), 24'(m_sel_a));
            check("sel_b", 24'(sel_b), 24'(m_sel_b));
            check("led_a", 24'(led_a), 24'(m_led_a));
            check("led_b", 24'(led_b), 24'(m_led_b));
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_reset_literals(input string tag);
        @(negedge sys_clk);
        check({tag, "_sel"}, 24'(sel_a), 24'h3E);
        check({tag, "_led"}, 24'(led_a), 24'hC0);
        check({tag, "_cnt"}, cnt_a, 24'h000000);
        check({tag, "_wrap"}, 24'(wrap_a), 24'h0);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            add_flag = 1'b1; tick();
            add_flag = 1'b0; tick();
        end
    endtask

    initial begin
        logic [7:0] scan_exp [6];
        int hits [6];
        int slot;
        bit seen;

        scan_exp = '{8'h92, 8'hC0, 8'hB0, 8'hFF, 8'hFF, 8'hFF};

        // Power-up reset held two cycles
        tick();
        chk_on = 1'b1;
        tick();
        check_reset_literals("rst");
        tick();
        sys_rst = 1'b0;
        tick();
        check_reset_literals("post_rst");

        // Decimal carry
        en = 1'b1;
        pulses(10);
        @(negedge sys_clk);
        check("carry10", cnt_a, 24'h000010);
        pulses(90);
        @(negedge sys_clk);
        check("carry100", cnt_a, 24'h000100);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            add_flag = ($urandom_range(1, 0) == 1);
            en       = ($urandom_range(3, 0) != 0);
            clr      = ($urandom_range(31, 0) == 0);
            tick();
        end
        add_flag = 1'b0; clr = 1'b0; en = 1'b1;

        // clr beats an increment; en low masks add_flag
        clr = 1'b1; tick(); clr = 1'b0;
        pulses(5);
        @(negedge sys_clk);
        check("pre_prio", cnt_a, 24'h000005);
        tick();
        clr = 1'b1; add_flag = 1'b1; tick();
        clr = 1'b0; add_flag = 1'b0;
        @(negedge sys_clk);
        check("prio_cnt", cnt_a, 24'h000000);
        check("prio_wrap", 24'(wrap_a), 24'h0);
        pulses(3);
        en = 1'b0; add_flag = 1'b1; tick(); tick();
        add_flag = 1'b0; en = 1'b1;
        @(negedge sys_clk);
        check("en_low", cnt_a, 24'h000003);

        // Scan of 000305 over one full frame
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        add_flag = 1'b1;
        repeat (305) tick();
        add_flag = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) hits[k] = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge sys_clk);
            seen = 1'b0;
            slot = 0;
            for (int k = 0; k < 6; k++) begin
                if (sel_a == ~(6'b000001 << k)) begin
                    seen = 1'b1;
                    slot = k;
                end
            end
            check("scan_sel_onehot", 24'(seen), 24'h1);
            if (seen) begin
                hits[slot]++;
                check("scan_led", 24'(led_a), 24'(scan_exp[slot]));
            end
        end
        for (int k = 0; k < 6; k++) check("scan_slot_len", 24'(hits[k]), 24'd4);

        // Blanking disabled: zero shows "0" in every slot
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        tick();
        for (int c = 0; c < 6 * SD_B; c++) begin
            @(negedge sys_clk);
            check("noblank_led", 24'(led_b), 24'hC0);
        end

        // Rollover from a forced 999999
        tick();
        force dut_a.count_reg = 24'h999999;
        force dut_b.count_reg = 24'h999999;
        m_cnt = 999999;
        tick();
        tick();
        release dut_a.count_reg;
        release dut_b.count_reg;
        add_flag = 1'b1; en = 1'b1;
        tick();
        add_flag = 1'b0;
        @(negedge sys_clk);
        check("roll_cnt", cnt_a, 24'h000000);
        check("roll_wrap_hi", 24'(wrap_a), 24'h1);
        tick();
        @(negedge sys_clk);
        check("roll_wrap_lo", 24'(wrap_a), 24'h0);

        // Reset while the scan sits on digit 3
        pulses(42);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge sys_clk);
            if (sel_a == 6'b110111) seen = 1'b1;
        end
        check("wait_idx3", 24'(seen), 24'h1);
        tick();
        sys_rst = 1'b1;
        tick();
        tick();
        check_reset_literals("mid_rst");
        tick();
        sys_rst = 1'b0;

        for (int i = 0; i < 200; i++) begin
            add_flag = ($urandom_range(1, 0) == 1);
            en       = ($urandom_range(3, 0) != 0);
            clr      = ($urandom_range(63, 0) == 0);
            tick();
        end
        add_flag = 1'b0; clr = 1'b0;
        tick();
        @(negedge sys_clk);
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
